// File: rtl/ra_bist_march_32x32.sv
// March C- BIST sequencer for the 32x32 register array.
// Drives array controls, compares both read ports and records the first miscompare.
module ra_bist_march_32x32 #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:31] bg_pat,
  output logic        rd0_enb,
  output logic [0:4]  rd0_adr,
  input  logic [0:31] rd0_dat,
  output logic        rd1_enb,
  output logic [0:4]  rd1_adr,
  input  logic [0:31] rd1_dat,
  output logic        wr0_enb,
  output logic [0:4]  wr0_adr,
  output logic [0:31] wr0_dat,
  output logic        active,
  output logic        done,
  output logic        fail,
  output logic [0:31] status
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  adr_reg;
  logic        phase_reg;
  logic [0:31] bg_reg;
  logic        fail_reg;
  logic [4:0]  fail_adr_reg;
  logic [2:0]  fail_elem_reg;
  logic [1:0]  fail_port_reg;
  logic [15:0] cnt_reg;

  // One stage per cycle of read latency; the last stage lines up with returning data.
  logic        pv_reg    [RD_LAT];
  logic [0:31] pexp_reg  [RD_LAT];
  logic [4:0]  padr_reg  [RD_LAT];
  logic [2:0]  pelem_reg [RD_LAT];

  logic        two_op;
  logic        is_read;
  logic        is_write;
  logic        rd_one;
  logic        wr_one;
  logic [2:0]  elem;
  logic [0:31] exp_dat;
  logic        mis0;
  logic        mis1;

  always_comb begin
    two_op   = state_reg inside {M1, M2, M3, M4};
    is_read  = (two_op && !phase_reg) || (state_reg == M5);
    is_write = (state_reg == M0) || (two_op && phase_reg);
    rd_one   = state_reg inside {M2, M4};
    wr_one   = state_reg inside {M1, M3};
    case (state_reg)
      M0:      elem = 3'd0;
      M1:      elem = 3'd1;
      M2:      elem = 3'd2;
      M3:      elem = 3'd3;
      M4:      elem = 3'd4;
      M5:      elem = 3'd5;
      default: elem = 3'd7;
    endcase
    exp_dat = rd_one ? ~bg_reg : bg_reg;
    mis0    = pv_reg[RD_LAT-1] && (rd0_dat != pexp_reg[RD_LAT-1]);
    mis1    = pv_reg[RD_LAT-1] && (rd1_dat != pexp_reg[RD_LAT-1]);
  end

  assign rd0_enb = is_read;
  assign rd1_enb = is_read;
  assign rd0_adr = is_read ? adr_reg : 5'd0;
  assign rd1_adr = is_read ? adr_reg : 5'd0;
  assign wr0_enb = is_write;
  assign wr0_adr = is_write ? adr_reg : 5'd0;
  assign wr0_dat = is_write ? (wr_one ? ~bg_reg : bg_reg) : 32'd0;
  assign active  = state_reg inside {M0, M1, M2, M3, M4, M5, DRAIN};
  assign done    = (state_reg == DONE);
  assign fail    = fail_reg;
  assign status  = {active, done, fail_reg, elem, fail_adr_reg, fail_port_reg,
                    fail_elem_reg, cnt_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      adr_reg       <= 5'd0;
      phase_reg     <= 1'b0;
      bg_reg        <= 32'd0;
      fail_reg      <= 1'b0;
      fail_adr_reg  <= 5'd0;
      fail_elem_reg <= 3'd0;
      fail_port_reg <= 2'd0;
      cnt_reg       <= 16'd0;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_reg[i]    <= 1'b0;
        pexp_reg[i]  <= 32'd0;
        padr_reg[i]  <= 5'd0;
        pelem_reg[i] <= 3'd0;
      end
    end else begin
      pv_reg[0]    <= is_read;
      pexp_reg[0]  <= exp_dat;
      padr_reg[0]  <= adr_reg;
      pelem_reg[0] <= elem;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_reg[i]    <= pv_reg[i-1];
        pexp_reg[i]  <= pexp_reg[i-1];
        padr_reg[i]  <= padr_reg[i-1];
        pelem_reg[i] <= pelem_reg[i-1];
      end

      if (mis0 || mis1) begin
        fail_reg <= 1'b1;
        if (cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
        if (!fail_reg) begin
          fail_adr_reg  <= padr_reg[RD_LAT-1];
          fail_elem_reg <= pelem_reg[RD_LAT-1];
          fail_port_reg <= {mis1, mis0};
        end
      end

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= M0;
            adr_reg       <= 5'd0;
            phase_reg     <= 1'b0;
            bg_reg        <= bg_pat;
            fail_reg      <= 1'b0;
            fail_adr_reg  <= 5'd0;
            fail_elem_reg <= 3'd0;
            fail_port_reg <= 2'd0;
            cnt_reg       <= 16'd0;
          end
        end
        M0: begin
          if (adr_reg == 5'd31) begin
            state_reg <= M1;
            adr_reg   <= 5'd0;
          end else begin
            adr_reg <= adr_reg + 5'd1;
          end
        end
        M1, M2: begin
          phase_reg <= ~phase_reg;
          if (phase_reg) begin
            if (adr_reg == 5'd31) begin
              state_reg <= (state_reg == M1) ? M2 : M3;
              adr_reg   <= (state_reg == M1) ? 5'd0 : 5'd31;
            end else begin
              adr_reg <= adr_reg + 5'd1;
            end
          end
        end
        M3, M4: begin
          phase_reg <= ~phase_reg;
          if (phase_reg) begin
            if (adr_reg == 5'd0) begin
              state_reg <= (state_reg == M3) ? M4 : M5;
              adr_reg   <= 5'd31;
            end else begin
              adr_reg <= adr_reg - 5'd1;
            end
          end
        end
        M5: begin
          if (adr_reg == 5'd0) begin
            state_reg <= DRAIN;
            adr_reg   <= 5'd0;
          end else begin
            adr_reg <= adr_reg - 5'd1;
          end
        end
        DRAIN: begin
          // adr doubles as the drain cycle counter
          if (adr_reg == 5'(RD_LAT - 1)) begin
            state_reg <= DONE;
            adr_reg   <= 5'd0;
          end else begin
            adr_reg <= adr_reg + 5'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
